// File: rtl/filter2d_kxk_if.sv
// Pixel stream interface for the KxK filter: input pixel channel and output result channel.
// The slave modport is the filter's view; the master modport is the source/sink side.
interface filter2d_kxk_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_sof;
    logic              out_eol;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sof, out_eol
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sof, out_eol
    );
endinterface

// File: rtl/filter2d_kxk.sv
// Streaming KxK 2D convolution over a raster-ordered single-channel pixel stream.
// K-1 line buffers feed a KxK window; a 3-stage pipeline (multiply, adder tree,
// shift+clamp) produces one saturated beat per valid window. Any output stall
// freezes every stage, so no skid buffering is needed.
//
//   state | meaning
//   IDLE  | waiting for start; coefficients writable
//   RUN   | accepting pixels of the current frame
//   DRAIN | all pixels in, waiting for the last output beat to be accepted
module filter2d_kxk #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int K      = 3,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    localparam int NT    = K * K,
    localparam int AW    = $clog2(NT),
    localparam int ACC_W = DATA_W + COEF_W + $clog2(NT) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [4:0]               cfg_shift,
    output logic                     busy,
    output logic                     frame_done,
    input  logic                     coef_we,
    input  logic [AW-1:0]            coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    filter2d_kxk_if.slave            px
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int PW = DATA_W + 1 + COEF_W;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_MIN  = XW'(K - 1);
    localparam logic [YW-1:0] Y_MIN  = YW'(K - 1);
    localparam logic signed [ACC_W-1:0] MAX_PIX = ACC_W'((1 << DATA_W) - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                   state;
    logic [XW-1:0]            x;
    logic [YW-1:0]            y;
    logic [4:0]               shift_q;
    logic signed [COEF_W-1:0] coef [NT];
    logic [DATA_W-1:0]        lb   [K-1][IMG_W];
    logic [DATA_W-1:0]        win  [K][K];
    logic [DATA_W-1:0]        col  [K];
    logic signed [PW-1:0]     prod [NT];
    logic signed [ACC_W-1:0]  sum_c;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  shifted;
    // flag vectors per stage: {last, eol, sof, valid}
    logic [3:0]               w_f, p_f, a_f;
    logic                     o_last;
    logic                     stall;
    logic                     acc_in;

    assign stall       = px.out_valid && !px.out_ready;
    assign px.in_ready = (state == RUN) && !stall;
    assign acc_in      = px.in_valid && px.in_ready;

    // Frame sequencing: start latches the shift, x/y walk the raster, last output ends the frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            x          <= '0;
            y          <= '0;
            shift_q    <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        shift_q <= cfg_shift;
                        x       <= '0;
                        y       <= '0;
                    end
                end
                RUN: begin
                    if (acc_in) begin
                        if (x == X_LAST) begin
                            x <= '0;
                            if (y == Y_LAST) state <= DRAIN;
                            else             y     <= y + 1'b1;
                        end else begin
                            x <= x + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (px.out_valid && px.out_ready && o_last) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Coefficient file; writes only land while idle, out-of-range taps are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NT; i++) coef[i] <= '0;
        end else if (coef_we && !busy && int'(coef_addr) < NT) begin
            coef[coef_addr] <= coef_data;
        end
    end

    // Column entering the window: row K-1 is the live pixel, older rows come from the line buffers.
    always_comb begin
        col[K-1] = px.in_data;
        for (int i = 0; i < K - 1; i++) col[K-2-i] = lb[i][x];
    end

    // Line buffers and window shift on accepted pixels only; contents need no reset.
    always_ff @(posedge clk) begin
        if (acc_in) begin
            lb[0][x] <= px.in_data;
            for (int i = 1; i < K - 1; i++) lb[i][x] <= lb[i-1][x];
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) win[r][c] <= win[r][c+1];
                win[r][K-1] <= col[r];
            end
        end
    end

    // Window qualification and flag pipeline; everything holds while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_f <= '0;
            p_f <= '0;
            a_f <= '0;
        end else if (!stall) begin
            w_f[0] <= acc_in && (x >= X_MIN) && (y >= Y_MIN);
            w_f[1] <= acc_in && (x == X_MIN) && (y == Y_MIN);
            w_f[2] <= acc_in && (x == X_LAST) && (y >= Y_MIN);
            w_f[3] <= acc_in && (x == X_LAST) && (y == Y_LAST);
            p_f    <= w_f;
            a_f    <= p_f;
        end
    end

    // Stage 1: one signed product per tap, pixel zero-extended to keep it non-negative.
    always_ff @(posedge clk) begin
        if (!stall) begin
            for (int i = 0; i < NT; i++)
                prod[i] <= $signed({1'b0, win[i / K][i % K]}) * coef[i];
        end
    end

    // Adder tree over all taps, sign-extended to the accumulator width.
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < NT; i++) sum_c = sum_c + ACC_W'(prod[i]);
    end

    // Stage 2: register the accumulated sum.
    always_ff @(posedge clk) begin
        if (!stall) acc <= sum_c;
    end

    // Arithmetic shift of the accumulator by the frame's latched amount.
    always_comb begin
        shifted = acc >>> shift_q;
    end

    // Stage 3: clamp into pixel range and present the beat; flags are zero on empty cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            px.out_valid <= 1'b0;
            px.out_data  <= '0;
            px.out_sof   <= 1'b0;
            px.out_eol   <= 1'b0;
            o_last       <= 1'b0;
        end else if (!stall) begin
            px.out_valid <= a_f[0];
            px.out_sof   <= a_f[0] && a_f[1];
            px.out_eol   <= a_f[0] && a_f[2];
            o_last       <= a_f[0] && a_f[3];
            if (!a_f[0])                px.out_data <= '0;
            else if (shifted < 0)       px.out_data <= '0;
            else if (shifted > MAX_PIX) px.out_data <= '1;
            else                        px.out_data <= shifted[DATA_W-1:0];
        end
    end
endmodule

// File: tb/tb_filter2d_kxk.sv
// Bench for filter2d_kxk: a K=3 8x6 instance and a K=5 16x8 instance share one
// stimulus path selected by sel. Expected beats are computed from the driven frame
// and queued as each completing pixel is accepted; a monitor pops and compares.
module tb_filter2d_kxk;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sel = 1'b0;
    logic              start = 1'b0;
    logic [4:0]        cfg_shift = '0;
    logic              coef_we = 1'b0;
    logic [4:0]        coef_addr = '0;
    logic signed [7:0] coef_data = '0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = '0;
    logic              out_ready = 1'b1;
    logic              busy3, busy5, done3, done5;
    logic              o_valid, o_sof, o_eol, i_ready, busy, fdone;
    logic [7:0]        o_data;

    always #5 clk = ~clk;

    filter2d_kxk_if #(.DATA_W(8)) b3 ();
    filter2d_kxk_if #(.DATA_W(8)) b5 ();

    assign b3.in_valid  = in_valid & ~sel;
    assign b3.in_data   = in_data;
    assign b3.out_ready = out_ready;
    assign b5.in_valid  = in_valid & sel;
    assign b5.in_data   = in_data;
    assign b5.out_ready = out_ready;

    filter2d_kxk #(.DATA_W(8), .COEF_W(8), .K(3), .IMG_W(8), .IMG_H(6)) u3 (
        .clk(clk), .rst(rst), .start(start & ~sel), .cfg_shift(cfg_shift),
        .busy(busy3), .frame_done(done3), .coef_we(coef_we & ~sel),
        .coef_addr(coef_addr[3:0]), .coef_data(coef_data), .px(b3.slave)
    );

    filter2d_kxk #(.DATA_W(8), .COEF_W(8), .K(5), .IMG_W(16), .IMG_H(8)) u5 (
        .clk(clk), .rst(rst), .start(start & sel), .cfg_shift(cfg_shift),
        .busy(busy5), .frame_done(done5), .coef_we(coef_we & sel),
        .coef_addr(coef_addr), .coef_data(coef_data), .px(b5.slave)
    );

    always_comb begin
        o_valid = sel ? b5.out_valid : b3.out_valid;
        o_data  = sel ? b5.out_data  : b3.out_data;
        o_sof   = sel ? b5.out_sof   : b3.out_sof;
        o_eol   = sel ? b5.out_eol   : b3.out_eol;
        i_ready = sel ? b5.in_ready  : b3.in_ready;
        busy    = sel ? busy5 : busy3;
        fdone   = sel ? done5 : done3;
    end

    typedef struct {
        int     data;
        bit     sof;
        bit     eol;
        longint cyc;
    } exp_t;

    exp_t   sbq[$];
    int     nvec = 0;
    int     nerr = 0;
    int     beats = 0;
    int     dones = 0;
    longint cyc = 0;
    bit     bp = 0;
    bit     lat_chk = 0;
    int     k = 3, w = 8, h = 6, sh = 0;
    int     cf [25];
    int     pix [8][16];

    function automatic int ref_px(input int xx, input int yy);
        int a;
        a = 0;
        for (int r = 0; r < k; r++)
            for (int c = 0; c < k; c++)
                a += pix[yy-k+1+r][xx-k+1+c] * cf[r*k+c];
        a = a >>> sh;
        if (a < 0)   a = 0;
        if (a > 255) a = 255;
        return a;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired nvec=%0d", nvec);
        $fatal(1, "watchdog");
    end

    // output monitor / scoreboard
    initial begin
        exp_t       e;
        logic       held_v, held_s, held_e;
        logic [7:0] held_d;
        held_v = 0; held_s = 0; held_e = 0; held_d = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                held_v = 0;
            end else begin
                if (fdone) dones++;
                if (held_v) begin
                    nvec++;
                    assert (o_valid === 1'b1 && o_data === held_d && o_sof === held_s && o_eol === held_e)
                    else begin nerr++; $error("FAIL hold got v=%0b d=%0d expected v=1 d=%0d", o_valid, o_data, held_d); end
                end
                if (o_valid && !out_ready) begin
                    nvec++;
                    assert (i_ready === 1'b0)
                    else begin nerr++; $error("FAIL stall_in_ready got %0b expected 0", i_ready); end
                end
                if (!o_valid) begin
                    nvec++;
                    assert ({o_sof, o_eol} === 2'b00)
                    else begin nerr++; $error("FAIL idle_flags got %b expected 00", {o_sof, o_eol}); end
                end
                if (o_valid && out_ready) begin
                    nvec++;
                    assert (sbq.size() != 0)
                    else begin nerr++; $error("FAIL extra_beat got data %0d expected no beat", o_data); end
                    if (sbq.size() != 0) begin
                        e = sbq.pop_front();
                        beats++;
                        nvec++;
                        assert (o_data === 8'(e.data))
                        else begin nerr++; $error("FAIL data got %0d expected %0d", o_data, e.data); end
                        nvec++;
                        assert (o_sof === e.sof && o_eol === e.eol)
                        else begin nerr++; $error("FAIL flags got sof=%0b eol=%0b expected sof=%0b eol=%0b", o_sof, o_eol, e.sof, e.eol); end
                        if (lat_chk) begin
                            nvec++;
                            assert (cyc - e.cyc === 64'sd3)
                            else begin nerr++; $error("FAIL latency got %0d expected 3", cyc - e.cyc); end
                        end
                    end
                end
                held_v = o_valid && !out_ready;
                held_d = o_data;
                held_s = o_sof;
                held_e = o_eol;
            end
        end
    end

    task automatic write_coef(input int a, input int v);
        coef_addr = 5'(a);
        coef_data = 8'(v);
        coef_we   = 1'b1;
        @(posedge clk); #1;
        coef_we   = 1'b0;
        cf[a]     = v;
    endtask

    task automatic set_all(input int v);
        for (int a = 0; a < k * k; a++) write_coef(a, v);
    endtask

    task automatic fill(input int mode, input int cval);
        for (int yy = 0; yy < h; yy++)
            for (int xx = 0; xx < w; xx++)
                case (mode)
                    0:       pix[yy][xx] = cval;
                    1:       pix[yy][xx] = 8 * yy + xx;
                    default: pix[yy][xx] = int'($urandom_range(0, 255));
                endcase
    endtask

    task automatic start_frame(input int s);
        cfg_shift = 5'(s);
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        sh        = s;
    endtask

    task automatic send_frame(input int npix);
        int   g, xx, yy;
        exp_t e;
        for (int i = 0; i < npix; i++) begin
            xx = i % w;
            yy = i / w;
            in_valid = 1'b1;
            in_data  = 8'(pix[yy][xx]);
            g = 0;
            do begin @(negedge clk); g++; end while (!i_ready && g < 1000);
            nvec++;
            assert (i_ready === 1'b1)
            else begin nerr++; $error("FAIL in_ready_timeout got %0b expected 1", i_ready); end
            if (i_ready !== 1'b1) begin in_valid = 1'b0; return; end
            if (xx >= k - 1 && yy >= k - 1) begin
                e.data = ref_px(xx, yy);
                e.sof  = (xx == k - 1) && (yy == k - 1);
                e.eol  = (xx == w - 1);
                e.cyc  = cyc + 1;
                sbq.push_back(e);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int b0, input int nb);
        int g;
        bit seen;
        g = 0;
        seen = 0;
        while (!seen && g < 3000) begin @(negedge clk); seen = fdone; g++; end
        nvec++;
        assert (seen)
        else begin nerr++; $error("FAIL frame_done_timeout got %0b expected 1", seen); end
        repeat (4) @(negedge clk);
        nvec++;
        assert (dones - d0 === 1)
        else begin nerr++; $error("FAIL done_count got %0d expected 1", dones - d0); end
        nvec++;
        assert (beats - b0 === nb)
        else begin nerr++; $error("FAIL beat_count got %0d expected %0d", beats - b0, nb); end
        nvec++;
        assert (sbq.size() === 0)
        else begin nerr++; $error("FAIL leftover got %0d expected 0", sbq.size()); end
        nvec++;
        assert (busy === 1'b0)
        else begin nerr++; $error("FAIL busy_after got %0b expected 0", busy); end
        @(posedge clk); #1;
    endtask

    task automatic run_frame(input int s);
        int d0, b0;
        d0 = dones;
        b0 = beats;
        start_frame(s);
        send_frame(w * h);
        wait_done(d0, b0, (w - k + 1) * (h - k + 1));
    endtask

    task automatic check_quiet(input string tag);
        nvec++;
        assert ({o_valid, o_sof, o_eol, i_ready, busy, fdone} === 6'b0 && o_data === 8'd0)
        else begin nerr++; $error("FAIL %s got v=%0b d=%0d rdy=%0b busy=%0b done=%0b expected all 0", tag, o_valid, o_data, i_ready, busy, fdone); end
    endtask

    initial begin
        int d0, b0;
        for (int i = 0; i < 25; i++) cf[i] = 0;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset_k3");
        sel = 1'b1; #1;
        check_quiet("reset_k5");
        sel = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // constant frame, box kernel; start and coef write during RUN must be ignored
        set_all(1);
        fill(0, 10);
        d0 = dones; b0 = beats;
        start_frame(0);
        coef_addr = 5'd0; coef_data = 8'sd5; coef_we = 1'b1;
        cfg_shift = 5'd3; start = 1'b1;
        @(posedge clk); #1;
        coef_we = 1'b0; start = 1'b0;
        nvec++;
        assert (busy === 1'b1)
        else begin nerr++; $error("FAIL busy_run got %0b expected 1", busy); end
        send_frame(w * h);
        wait_done(d0, b0, 24);

        // identity kernel on a ramp, fixed latency
        set_all(0);
        write_coef(4, 1);
        fill(1, 0);
        lat_chk = 1;
        run_frame(0);
        lat_chk = 0;

        // saturation corners
        set_all(1);
        fill(0, 255);
        run_frame(0);
        set_all(-1);
        run_frame(0);
        set_all(16);
        run_frame(4);

        // random kernel under 30% output-ready backpressure
        for (int a = 0; a < 9; a++) write_coef(a, int'($urandom_range(0, 255)) - 128);
        fill(2, 0);
        bp = 1;
        run_frame(int'($urandom_range(0, 9)));
        bp = 0;
        @(posedge clk); #1;

        // reset mid-frame, then coefficients must be back to zero and frames correct again
        set_all(1);
        fill(0, 10);
        d0 = dones;
        start_frame(0);
        send_frame(20);
        rst = 1'b0;
        #1;
        check_quiet("reset_mid");
        sbq.delete();
        for (int i = 0; i < 25; i++) cf[i] = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        nvec++;
        assert (dones === d0)
        else begin nerr++; $error("FAIL done_on_reset got %0d expected %0d", dones, d0); end
        run_frame(0);
        set_all(1);
        run_frame(0);

        // K=5 instance, random pixels, coefficients and shift
        sel = 1'b1;
        k = 5; w = 16; h = 8;
        @(posedge clk); #1;
        for (int a = 0; a < 25; a++) write_coef(a, int'($urandom_range(0, 32)) - 8);
        fill(2, 0);
        run_frame(int'($urandom_range(4, 7)));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
